// File: rtl/rv32i_pkg.sv
// Shared rv32i pipeline definitions: register-file geometry, scoreboard
// defaults and the operand-forwarding select encodings used by EX.
package rv32i_pkg;

    localparam int REG_ADDR_W      = 5;
    localparam int NUM_REGS        = 32;
    localparam int MAX_PENDING_DEF = 4;
    localparam int PEND_CNT_W      = 4;

    // Operand-forwarding mux selects driven by the EX-stage hazard logic.
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard for long-latency writers (loads, mul/div).
// A destination is marked busy when it issues from decode and released on
// writeback; decode/fetch stall on RAW/WAW hits against busy registers and
// when the outstanding-write budget is exhausted.
// Build option: define SB_WB_BYPASS_EN to let a same-cycle writeback release
// its dependents and free its slot in the cycle it arrives.
module hazard_scoreboard #(
    parameter int NUM_REGS    = rv32i_pkg::NUM_REGS,
    parameter int MAX_PENDING = rv32i_pkg::MAX_PENDING_DEF
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0]    rs1D,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0]    rs2D,
    input  logic                                useRs1D,
    input  logic                                useRs2D,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0]    rdD,
    input  logic                                RegWriteD,
    input  logic                                issue_valid,
    output logic                                issue_ready,
    input  logic                                flushD,
    input  logic                                wb_valid,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0]    wb_rd,
    output logic                                stallF,
    output logic                                stallD,
    output logic [NUM_REGS-1:0]                 busy_vec,
    output logic [rv32i_pkg::PEND_CNT_W-1:0]    pending_count,
    output logic                                sb_error
);
    import rv32i_pkg::*;

`ifdef SB_WB_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    localparam logic [PEND_CNT_W-1:0] MAX_CNT = PEND_CNT_W'(MAX_PENDING);
    // x0 is hard-wired zero, so it can never be tracked as busy.
    localparam logic [NUM_REGS-1:0]   X0_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

    logic [NUM_REGS-1:0]   busy_reg, busy_next;
    logic [PEND_CNT_W-1:0] count_reg, count_next;
    logic                  err_reg, err_next;

    logic [NUM_REGS-1:0]   rs1_oh, rs2_oh, rd_oh, wb_oh;
    logic [NUM_REGS-1:0]   wb_release, eff_busy;
    logic                  wb_hit, wb_stray, hazard, full, issue_fire, underflow;

    // One-hot decode of every register address compared against the busy vector.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            assign rs1_oh[gi] = (rs1D  == REG_ADDR_W'(gi));
            assign rs2_oh[gi] = (rs2D  == REG_ADDR_W'(gi));
            assign rd_oh[gi]  = (rdD   == REG_ADDR_W'(gi));
            assign wb_oh[gi]  = (wb_rd == REG_ADDR_W'(gi));
        end
    endgenerate

    // A writeback only retires work if its register is actually busy; anything
    // else (except x0) means the pipeline and the scoreboard disagree.
    assign wb_hit     = wb_valid & |(wb_oh & busy_reg);
    assign wb_stray   = wb_valid & (wb_rd != '0) & ~wb_hit;

    assign wb_release = (BYPASS && wb_valid) ? wb_oh : '0;
    assign eff_busy   = busy_reg & ~wb_release & X0_MASK;

    assign hazard = (useRs1D   & |(rs1_oh & eff_busy))
                  | (useRs2D   & |(rs2_oh & eff_busy))
                  | (RegWriteD & |(rd_oh  & eff_busy));

    assign full = (count_reg == MAX_CNT) & ~(wb_hit & BYPASS);

    assign issue_ready = issue_valid & ~flushD & ~hazard & ~full;
    assign stallD      = ~flushD & (hazard | (issue_valid & full));
    assign stallF      = stallD;

    // Issues to x0 are accepted but never tracked.
    assign issue_fire  = issue_ready & (rdD != '0);

    // Next-state: clear on writeback, then set on issue so a same-register
    // issue/writeback pair leaves the bit set; count saturates at both ends.
    always_comb begin
        busy_next  = busy_reg;
        count_next = count_reg;
        underflow  = 1'b0;
        if (wb_hit) begin
            busy_next = busy_next & ~wb_oh;
        end
        if (issue_fire) begin
            busy_next = busy_next | rd_oh;
        end
        busy_next = busy_next & X0_MASK;
        case ({issue_fire, wb_hit})
            2'b10: begin
                if (count_reg != MAX_CNT) begin
                    count_next = count_reg + 1'b1;
                end
            end
            2'b01: begin
                if (count_reg == '0) begin
                    underflow = 1'b1;
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end
            default: count_next = count_reg;
        endcase
        err_next = err_reg | wb_stray | underflow;
    end

    // State registers; reset drops all tracking and clears the sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg  <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            busy_reg  <= busy_next;
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    assign busy_vec      = busy_reg;
    assign pending_count = count_reg;
    assign sb_error      = err_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// randomized traffic, all checked against a register-level behavioural model.
module tb_hazard_scoreboard;

`ifdef SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int MAXP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1D, rs2D, rdD, wb_rd;
    logic        useRs1D, useRs2D, RegWriteD, issue_valid, flushD, wb_valid;
    logic        issue_ready, stallF, stallD, sb_error;
    logic [31:0] busy_vec;
    logic [3:0]  pending_count;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state
    bit m_busy [32];
    int m_cnt;
    bit m_err;

    hazard_scoreboard #(.NUM_REGS(32), .MAX_PENDING(MAXP)) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
        .rdD(rdD), .RegWriteD(RegWriteD),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .flushD(flushD),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .stallF(stallF), .stallD(stallD),
        .busy_vec(busy_vec), .pending_count(pending_count), .sb_error(sb_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_eff(input int r);
        if (r == 0) return 1'b0;
        if (BYP && wb_valid && int'(wb_rd) == r) return 1'b0;
        return m_busy[r];
    endfunction

    task automatic idle();
        reset = 0; rs1D = 0; rs2D = 0; useRs1D = 0; useRs2D = 0;
        rdD = 0; RegWriteD = 0; issue_valid = 0; flushD = 0;
        wb_valid = 0; wb_rd = 0;
    endtask

    task automatic issue(input int r);
        issue_valid = 1; RegWriteD = 1; rdD = 5'(r);
    endtask

    // Called at posedge+1 with inputs driven: check, update model, advance.
    task automatic step();
        bit          haz, full, rdy, stl, wbhit;
        logic [31:0] exp_busy;
        #3;
        haz  = (useRs1D && m_eff(rs1D)) || (useRs2D && m_eff(rs2D)) ||
               (RegWriteD && m_eff(rdD));
        wbhit = wb_valid && wb_rd != 0 && m_busy[wb_rd];
        full = (m_cnt == MAXP) && !(BYP && wbhit);
        rdy  = issue_valid && !flushD && !haz && !full;
        stl  = !flushD && (haz || (issue_valid && full));
        exp_busy = '0;
        for (int i = 1; i < 32; i++) exp_busy[i] = m_busy[i];
        chk("stallD", 32'(stallD), 32'(stl));
        chk("stallF", 32'(stallF), 32'(stl));
        chk("issue_ready", 32'(issue_ready), 32'(rdy));
        chk("busy_vec", busy_vec, exp_busy);
        chk("pending_count", 32'(pending_count), 32'(m_cnt));
        chk("sb_error", 32'(sb_error), 32'(m_err));
        $display("t=%0t rst=%0b iss=%0b rd=%0d wb=%0b wbrd=%0d fl=%0b -> stall=%0b rdy=%0b cnt=%0d err=%0b",
                 $time, reset, issue_valid, rdD, wb_valid, wb_rd, flushD,
                 stallD, issue_ready, pending_count, sb_error);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
            m_cnt = 0; m_err = 0;
        end else begin
            if (wb_valid && wb_rd != 0 && !m_busy[wb_rd]) m_err = 1;
            if (wbhit) begin
                m_busy[wb_rd] = 0;
                if (m_cnt == 0) m_err = 1; else m_cnt--;
            end
            if (rdy && rdD != 0) begin
                m_busy[rdD] = 1;
                if (m_cnt < MAXP) m_cnt++;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        idle();
        reset = 1;
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
        m_cnt = 0; m_err = 0;
        @(posedge clk); @(posedge clk); #1;
        step();                       // reset state check
        idle();

        // 1: RAW on a pending load
        issue(5); step(); idle();
        useRs1D = 1; rs1D = 5; rdD = 10; RegWriteD = 1;
        step(); step(); step();
        wb_valid = 1; wb_rd = 5; step();
        wb_valid = 0; step(); idle();

        // 2: pending budget exhausted
        for (int r = 1; r <= 4; r++) begin issue(r); step(); end
        chk("count_full", 32'(pending_count), 32'd4);
        issue(6); step();
        wb_valid = 1; wb_rd = 1; step();
        wb_valid = 0; step(); idle();
        for (int r = 2; r <= 6; r++) begin
            if (r != 5) begin wb_valid = 1; wb_rd = 5'(r); step(); end
        end
        idle(); step();
        chk("count_drained", 32'(pending_count), 32'd0);

        // 3: x0 is never tracked
        issue(0); step(); idle();
        chk("x0_busy", busy_vec, 32'd0);
        useRs1D = 1; rs1D = 0; useRs2D = 1; rs2D = 0; wb_valid = 1; wb_rd = 0;
        step(); idle();
        chk("x0_no_err", 32'(sb_error), 32'd0);

        // 4: WAW on a pending write
        issue(7); step(); idle();
        RegWriteD = 1; rdD = 7; step(); step();
        wb_valid = 1; wb_rd = 7; step();
        wb_valid = 0; step(); idle();

        // 5: stray writeback sets sticky error
        wb_valid = 1; wb_rd = 9; step(); idle();
        step(); step();
        chk("err_sticky", 32'(sb_error), 32'd1);

        // 6: reset mid-operation, then flush with a hazard present
        issue(3); step(); idle();
        reset = 1; step(); idle();
        chk("rst_count", 32'(pending_count), 32'd0);
        issue(3); step(); idle();
        flushD = 1; useRs1D = 1; rs1D = 3; issue(12); step(); idle();
        wb_valid = 1; wb_rd = 3; step(); idle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            reset       = ($urandom_range(0, 63) == 0);
            issue_valid = $urandom_range(0, 1);
            rdD         = 5'($urandom_range(0, 7));
            RegWriteD   = issue_valid ? 1'b1 : 1'($urandom_range(0, 1));
            useRs1D     = $urandom_range(0, 1);
            useRs2D     = $urandom_range(0, 1);
            rs1D        = 5'($urandom_range(0, 7));
            rs2D        = 5'($urandom_range(0, 7));
            flushD      = ($urandom_range(0, 9) == 0);
            wb_valid    = ($urandom_range(0, 2) == 0);
            wb_rd       = 5'($urandom_range(0, 7));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
